// File: rtl/regfile_pkg.sv
// Shared constants and forwarding-priority selection for the parametrised register file.
// Optional cycle counter lives in regfile_fwd_param, enabled by REGFILE_CYCLE_CNT_EN.
package regfile_pkg;

    localparam int DW_DEF       = 32;
    localparam int AW_DEF       = 5;
    localparam int ZERO_REG     = 0;
    localparam int LINK_REG_DEF = 31;
    localparam int CNT_REG_DEF  = 30;

    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_EX,
        SRC_ME,
        SRC_WB,
        SRC_ARR
    } fwd_src_e;

    // Youngest producer wins; register 0 is hard-wired and never forwarded.
    function automatic fwd_src_e fwd_select(input logic is_zero,
                                            input logic hit_ex,
                                            input logic hit_me,
                                            input logic hit_wb);
        if (is_zero)     return SRC_ZERO;
        else if (hit_ex) return SRC_EX;
        else if (hit_me) return SRC_ME;
        else if (hit_wb) return SRC_WB;
        else             return SRC_ARR;
    endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port: EX/ME/WB forwarding mux plus the load-use compare for that port.
// Purely combinational; the array read value comes in from the top.
module regfile_fwd_mux
    import regfile_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] arr_data,
    input  logic          we_ex,
    input  logic [AW-1:0] wa_ex,
    input  logic [DW-1:0] wd_ex,
    input  logic          ld_ex,
    input  logic          we_me,
    input  logic [AW-1:0] wa_me,
    input  logic [DW-1:0] wd_me,
    input  logic          ld_me,
    input  logic          we_wb,
    input  logic [AW-1:0] wa_wb,
    input  logic [DW-1:0] wd_wb,
    output logic [DW-1:0] rd_data,
    output logic          load_use
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic     is_zero;
    logic     hit_ex;
    logic     hit_me;
    logic     hit_wb;
    fwd_src_e src;

    assign is_zero = (addr == ZERO_A);
    assign hit_ex  = we_ex && (wa_ex == addr);
    assign hit_me  = we_me && (wa_me == addr);
    assign hit_wb  = we_wb && (wa_wb == addr);
    assign src     = fwd_select(is_zero, hit_ex, hit_me, hit_wb);

    always_comb begin
        rd_data = '0;
        case (src)
            SRC_EX:  rd_data = wd_ex;
            SRC_ME:  rd_data = wd_me;
            SRC_WB:  rd_data = wd_wb;
            SRC_ARR: rd_data = arr_data;
            default: rd_data = '0;
        endcase
    end

    // With a 2-cycle memory a load still in ME has no data to forward yet.
    assign load_use = !is_zero &&
                      ((hit_ex && ld_ex) || ((MEM_LAT == 2) && hit_me && ld_me));

endmodule

// File: rtl/regfile_fwd_param.sv
// Parametrised integer register file: NRD forwarded read ports, WB + link write ports.
// Define REGFILE_CYCLE_CNT_EN to turn register CNT_REG into a free-running cycle counter.
module regfile_fwd_param
    import regfile_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NRD      = 2,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int CNT_REG  = CNT_REG_DEF,
    parameter int MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              we,
    input  logic [AW-1:0]     w_addr,
    input  logic [DW-1:0]     w_data,
    input  logic              link_we,
    input  logic [DW-1:0]     link_data,
    input  logic              we_ex,
    input  logic [AW-1:0]     wa_ex,
    input  logic [DW-1:0]     wd_ex,
    input  logic              ld_ex,
    input  logic              we_me,
    input  logic [AW-1:0]     wa_me,
    input  logic [DW-1:0]     wd_me,
    input  logic              ld_me,
    input  logic              we_wb,
    input  logic [AW-1:0]     wa_wb,
    input  logic [DW-1:0]     wd_wb,
    output logic              pause
);

    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);
    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
    localparam logic [AW-1:0] CNT_A  = AW'(CNT_REG);

`ifdef REGFILE_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_fwd_param: NRD must be 1..4");
    end
    if (MEM_LAT != 1 && MEM_LAT != 2) begin : g_bad_lat
        $error("regfile_fwd_param: MEM_LAT must be 1 or 2");
    end
    if (LINK_REG == CNT_REG || LINK_REG == ZERO_REG || CNT_REG == ZERO_REG ||
        LINK_REG >= NREG || CNT_REG >= NREG) begin : g_bad_idx
        $error("regfile_fwd_param: illegal LINK_REG/CNT_REG index");
    end

    logic [DW-1:0]  regs [NREG];
    logic [NRD-1:0] load_use;
    logic           w_ok;

    // we is the pipeline-advance qualifier: when low, neither the WB port nor the link
    // port nor the counter changes state; pause is advisory and never gates writes.
    assign w_ok = (w_addr != ZERO_A) && (w_addr != LINK_A) && !(CNT_EN && (w_addr == CNT_A));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            if (w_ok)    regs[w_addr] <= w_data;
            if (link_we) regs[LINK_A] <= link_data;
            if (CNT_EN)  regs[CNT_A]  <= regs[CNT_A] + 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] addr_k;
        assign addr_k = rd_addr[k*AW +: AW];

        regfile_fwd_mux #(
            .DW     (DW),
            .AW     (AW),
            .MEM_LAT(MEM_LAT)
        ) u_mux (
            .addr    (addr_k),
            .arr_data(regs[addr_k]),
            .we_ex   (we_ex),
            .wa_ex   (wa_ex),
            .wd_ex   (wd_ex),
            .ld_ex   (ld_ex),
            .we_me   (we_me),
            .wa_me   (wa_me),
            .wd_me   (wd_me),
            .ld_me   (ld_me),
            .we_wb   (we_wb),
            .wa_wb   (wa_wb),
            .wd_wb   (wd_wb),
            .rd_data (rd_data[k*DW +: DW]),
            .load_use(load_use[k])
        );
    end

    assign pause = |load_use;

endmodule

// File: tb/tb_regfile_fwd_param.sv
// Self-checking bench: a 2-port/1-cycle file and a 4-port/2-cycle file share all write
// and pipeline inputs; a reference array predicts every read.
module tb_regfile_fwd_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  rd_addr2 = '0;
    logic [19:0] rd_addr4 = '0;
    logic [63:0] rd_data2;
    logic [127:0] rd_data4;
    logic        we = 0, link_we = 0;
    logic [4:0]  w_addr = '0;
    logic [31:0] w_data = '0, link_data = '0;
    logic        we_ex = 0, ld_ex = 0, we_me = 0, ld_me = 0, we_wb = 0;
    logic [4:0]  wa_ex = '0, wa_me = '0, wa_wb = '0;
    logic [31:0] wd_ex = '0, wd_me = '0, wd_wb = '0;
    logic        pause2, pause4;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int n_total = 0;
    int n_bad   = 0;

    regfile_fwd_param dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .we(we), .w_addr(w_addr), .w_data(w_data), .link_we(link_we), .link_data(link_data),
        .we_ex(we_ex), .wa_ex(wa_ex), .wd_ex(wd_ex), .ld_ex(ld_ex),
        .we_me(we_me), .wa_me(wa_me), .wd_me(wd_me), .ld_me(ld_me),
        .we_wb(we_wb), .wa_wb(wa_wb), .wd_wb(wd_wb), .pause(pause2)
    );

    regfile_fwd_param #(.NRD(4), .MEM_LAT(2)) dut4 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .we(we), .w_addr(w_addr), .w_data(w_data), .link_we(link_we), .link_data(link_data),
        .we_ex(we_ex), .wa_ex(wa_ex), .wd_ex(wd_ex), .ld_ex(ld_ex),
        .we_me(we_me), .wa_me(wa_me), .wd_me(wd_me), .ld_me(ld_me),
        .we_wb(we_wb), .wa_wb(wa_wb), .wd_wb(wd_wb), .pause(pause4)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // checking and scoreboard
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check_val(tag, got, e);
    endtask

    // drivers
    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            input logic lwe, input logic [31:0] ld);
        @(negedge clk);
        we = 1; w_addr = a; w_data = d; link_we = lwe; link_data = ld;
        @(posedge clk);
        #1;
        we = 0; link_we = 0;
`ifdef REGFILE_CYCLE_CNT_EN
        if (a != 0 && a != 31 && a != 30) model[a] = d;
        model[30] = model[30] + 1;
`else
        if (a != 0 && a != 31) model[a] = d;
`endif
        if (lwe) model[31] = ld;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic read2(input int port, input logic [4:0] a, input logic [31:0] e,
                         input string tag);
        @(negedge clk);
        rd_addr2[port*5 +: 5] = a;
        push_exp(e);
        #1;
        pop_check(tag, rd_data2[port*32 +: 32]);
    endtask

    task automatic clear_fwd();
        we_ex = 0; ld_ex = 0; we_me = 0; ld_me = 0; we_wb = 0;
        wa_ex = 0; wa_me = 0; wa_wb = 0; wd_ex = 0; wd_me = 0; wd_wb = 0;
    endtask

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        model_clear();
        idle_cycles(3);
        @(negedge clk) rst = 1;

        // reset state, all addresses
        for (int i = 0; i < 32; i++) read2(i % 2, 5'(i), 32'd0, "reset_read");

        // zero register ignores writes
        do_write(5'd0, 32'hDEAD, 1'b0, '0);
        read2(0, 5'd0, 32'd0, "zero_reg");

        // random writes then reads through the array
        for (int i = 0; i < 10; i++) begin
            a = 5'($urandom_range(1, 29));
            d = $urandom;
            do_write(a, d, 1'b0, '0);
        end
        for (int i = 0; i < 10; i++) begin
            a = 5'($urandom_range(1, 29));
            read2($urandom_range(0, 1), a, model[a], "rand_read");
        end

        // mid-run reset with a write in flight
        @(negedge clk);
        we = 1; w_addr = 5'd3; w_data = 32'h77;
        #2 rst = 0;
        @(posedge clk);
        #1 we = 0;
        model_clear();
        @(negedge clk) rst = 1;
        for (int i = 0; i < 32; i++) read2(i % 2, 5'(i), 32'd0, "midrst_read");

        // forwarding priority on port 1
        for (int i = 1; i <= 5; i++) do_write(5'(i), 32'h100 + 32'(i), 1'b0, '0);
        @(negedge clk);
        we_ex = 1; wa_ex = 5; wd_ex = 32'h11;
        we_me = 1; wa_me = 5; wd_me = 32'h22;
        we_wb = 1; wa_wb = 5; wd_wb = 32'h33;
        read2(1, 5'd5, 32'h11, "fwd_ex");
        check_val("fwd_ex_nopause", 32'(pause2), 32'd0);
        we_ex = 0;
        read2(1, 5'd5, 32'h22, "fwd_me");
        we_me = 0;
        read2(1, 5'd5, 32'h33, "fwd_wb");
        we_wb = 0;
        read2(1, 5'd5, 32'h105, "fwd_none");
        wa_ex = 0; wd_ex = 32'hBEEF; we_ex = 1;
        read2(1, 5'd0, 32'd0, "fwd_zero");
        clear_fwd();

        // load-use stall
        @(negedge clk);
        rd_addr2 = '0; rd_addr4 = '0;
        rd_addr2[4:0] = 5'd7; rd_addr4[4:0] = 5'd7;
        we_ex = 1; ld_ex = 1; wa_ex = 7;
        #1;
        check_val("lu_ex_p2", 32'(pause2), 32'd1);
        check_val("lu_ex_p4", 32'(pause4), 32'd1);
        ld_ex = 0;
        #1 check_val("lu_noload", 32'(pause2), 32'd0);
        ld_ex = 1; wa_ex = 0; rd_addr2[4:0] = 5'd0; rd_addr4[4:0] = 5'd0;
        #1 check_val("lu_zero_p2", 32'(pause2), 32'd0);
        check_val("lu_zero_p4", 32'(pause4), 32'd0);
        we_ex = 0; ld_ex = 0;
        rd_addr2[4:0] = 5'd7; rd_addr4[4:0] = 5'd7;
        we_me = 1; ld_me = 1; wa_me = 7;
        #1 check_val("lu_me_lat1", 32'(pause2), 32'd0);
        check_val("lu_me_lat2", 32'(pause4), 32'd1);
        clear_fwd();

        // link port
        do_write(5'd31, 32'hAAAA, 1'b1, 32'h400);
        read2(0, 5'd31, 32'h400, "link_write");
        @(negedge clk);
        link_we = 1; link_data = 32'h999;
        @(posedge clk);
        #1 link_we = 0;
        read2(0, 5'd31, 32'h400, "link_frozen");
        do_write(5'd9, 32'h9999, 1'b1, 32'h800);
        read2(0, 5'd9, 32'h9999, "link_pair_wb");
        read2(1, 5'd31, 32'h800, "link_pair_lr");

`ifdef REGFILE_CYCLE_CNT_EN
        @(negedge clk) rst = 0;
        model_clear();
        @(negedge clk) rst = 1;
        for (int i = 0; i < 10; i++) do_write(5'd1, $urandom, 1'b0, '0);
        idle_cycles(3);
        read2(0, 5'd30, 32'd10, "cnt_ten");
        do_write(5'd30, 32'h55, 1'b0, '0);
        read2(0, 5'd30, 32'd11, "cnt_wr_ignored");
`else
        do_write(5'd30, 32'h55, 1'b0, '0);
        read2(0, 5'd30, 32'h55, "cnt_plain_reg");
`endif

        // four independent ports
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rd_addr4[k*5 +: 5] = 5'(k + 1);
            push_exp(model[k + 1]);
        end
        #1;
        for (int k = 0; k < 4; k++) pop_check("nrd4_port", rd_data4[k*32 +: 32]);

        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_fwd_param.md
Name: regfile_fwd_param

Overview:
- Parametrised integer register file for the 5-stage pipeline, replacing the fixed 32x32, 2-read-port file.
- Provides:
  - N read ports with EX/ME/WB forwarding.
  - Load-use stall generation for 1- or 2-cycle data memory.
  - A dedicated link-register write port.
  - An optional hardware cycle-counter register.
- Sits in ID; read data feeds ID/EX; write port is driven by WB.

Parameters:
- DW, 32, data width in bits.
- AW, 5, register address width; NREG = 2**AW.
- NRD, 2, number of read ports (1..4).
- LINK_REG, 31, index written only via link port.
- CNT_REG, 30, index used as cycle counter when feature enabled.
- MEM_LAT, 1, data memory read latency (1 or 2); sets stall depth.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  packed read addresses, port k at [k*AW +: AW].
- rd_data  out  NRD*DW  packed read data, port k at [k*DW +: DW].
- we  in  1  pipeline-advance / write enable for WB write.
- w_addr  in  AW  WB write address.
- w_data  in  DW  WB write data.
- link_we  in  1  link-register write request.
- link_data  in  DW  return address.
- we_ex, wa_ex, wd_ex, ld_ex  in  1/AW/DW/1  EX-stage write enable, address, data, load flag.
- we_me, wa_me, wd_me, ld_me  in  1/AW/DW/1  ME-stage equivalents.
- we_wb, wa_wb, wd_wb  in  1/AW/DW  WB-stage equivalents.
- pause  out  1  load-use stall request to the hazard unit.

Behaviour:
- Reset: all NREG registers cleared to 0 asynchronously. Reset mid-operation drops any write in flight that cycle.
- Read path, per port k, combinational, zero latency:
  - addr==0 returns 0 always; never forwarded.
  - Otherwise priority is EX (we_ex && wa_ex==addr) > ME > WB > array.
  - Youngest producer wins when several match.
- Write on posedge clk when we=1:
  - regs[w_addr] <= w_data, unless w_addr is 0 or LINK_REG. Those writes are silently dropped.
  - If link_we=1, regs[LINK_REG] <= link_data, in the same cycle as any normal write.
  - we=0 blocks both writes, since the pipeline is frozen.
- Read-during-write: forwarding covers WB; the array value is the pre-edge value.
- pause is combinational. It is 1 when any port k has addr!=0 and:
  - (we_ex && ld_ex && wa_ex==addr), or
  - MEM_LAT==2 and (we_me && ld_me && wa_me==addr).
- pause does not gate writes. The hazard unit holds the ID/EX registers.
- Width rules: counter increment is modulo 2**DW and wraps to 0.
- Out-of-range parameters (NRD>4, MEM_LAT not 1/2, LINK_REG==CNT_REG, either index 0) cause an elaboration error via generate-time $error.

Optional Feature:
- Macro REGFILE_CYCLE_CNT_EN.
- When defined:
  - regs[CNT_REG] increments by 1 on every posedge with we=1.
  - Normal writes to CNT_REG are dropped; the counter has priority.
  - Reads of CNT_REG still forward from EX/ME/WB if matched.
- When undefined: CNT_REG is an ordinary register.

Decomposition:
- Shared package regfile_pkg holds:
  - Default DW/AW constants.
  - ZERO_REG=0.
  - Default LINK_REG/CNT_REG indices.
  - A function for the forwarding-priority mux.
- One sub-module, regfile_fwd_mux: a single read port's forwarding mux plus load-use compare, instantiated NRD times in a generate loop.
- The array and write logic stay in the top module.

Test Plan:
- Reset and zero register:
  - Stimulus: rst=0 mid-run, release, then read all addresses; also write addr 0 with 0xDEAD, read port0 addr 0.
  - Response: all reads 0; addr 0 reads 0.
- Forwarding priority:
  - Stimulus: we_ex/wa_ex=5/0x11, we_me/wa_me=5/0x22, we_wb/wa_wb=5/0x33; read 5 on port1.
  - Response: 0x11. Drop EX: 0x22. Drop ME: 0x33.
- Load-use stall:
  - Stimulus: ld_ex=1, we_ex=1, wa_ex=7, rd_addr port0=7.
  - Response: pause=1.
  - Stimulus: same with wa_ex=0 and addr 0.
  - Response: pause=0.
  - Stimulus: MEM_LAT=2 with ld_me=1, wa_me=7.
  - Response: pause=1.
- Link port:
  - Stimulus: we=1, w_addr=31/0xAAAA, link_we=1/0x400.
  - Response: reg31=0x400 next cycle.
  - Stimulus: we=0, link_we=1.
  - Response: reg31 unchanged.
- Cycle counter, with REGFILE_CYCLE_CNT_EN:
  - Stimulus: 10 cycles of we=1, 3 cycles of we=0.
  - Response: reg30=10.
  - Stimulus: write reg30=0x55.
  - Response: still incrementing, write ignored.
  - Stimulus: preload via force to 0xFFFFFFFF, then one cycle.
  - Response: 0.
  - Without the macro: write 0x55 to reg30 reads back 0x55.
- NRD=4 build:
  - Stimulus: write regs 1..4, read all four ports simultaneously.
  - Response: each port returns its own value independently.
